// File: rtl/if_stage_pkg.sv
// Shared CPU constants (reset PC, exception vector, instruction memory window, NOP)
// and fetch helpers used by the fetch stage, decoder and CP0.
package if_stage_pkg;

  localparam logic [31:0] CPU_PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] CPU_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] CPU_IM_LO      = 32'h0000_3000;
  localparam logic [31:0] CPU_IM_HI      = 32'h0000_6FFC;
  localparam logic [31:0] CPU_NOP        = 32'h0000_0000;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'd0,
    PC_SEL_JUMP = 2'd1,
    PC_SEL_HOLD = 2'd2,
    PC_SEL_EXC  = 2'd3
  } pc_sel_e;

  // A fetch faults when misaligned or outside the inclusive [lo, hi] window.
  function automatic logic fetch_fault(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Link between the fetch logic (master) and the IF/ID pipeline register (slave).
interface if_stage_if;
  // The fetch side presents a slot every cycle; cap_en is valid&ready (low while
  // stalled, so the register holds), and flush wins over cap_en and empties it.
  logic        cap_en;
  logic        flush;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_adel;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        d_adel;

  modport master (
    output cap_en, flush, f_pc, f_instr, f_adel,
    input  d_instr, d_pc, d_valid, d_adel
  );

  modport slave (
    input  cap_en, flush, f_pc, f_instr, f_adel,
    output d_instr, d_pc, d_valid, d_adel
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: capture a fetched slot, hold it, or flush it to an empty nop.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  if_stage_if.slave  ifid
);

  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_adel_q, d_adel_d;

  always_comb begin
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    d_adel_d  = d_adel_q;
    if (ifid.flush) begin
      d_instr_d = CPU_NOP;
      d_pc_d    = 32'h0;
      d_valid_d = 1'b0;
      d_adel_d  = 1'b0;
    end else if (ifid.cap_en) begin
      d_instr_d = ifid.f_instr;
      d_pc_d    = ifid.f_pc;
      d_valid_d = 1'b1;
      d_adel_d  = ifid.f_adel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_instr_q <= CPU_NOP;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
      d_adel_q  <= 1'b0;
    end else begin
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      d_adel_q  <= d_adel_d;
    end
  end

  assign ifid.d_instr = d_instr_q;
  assign ifid.d_pc    = d_pc_q;
  assign ifid.d_valid = d_valid_q;
  assign ifid.d_adel  = d_adel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register with exception/stall/jump/sequential selection,
// fault screening of the fetch address, and the IF/ID register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = CPU_PC_RESET,
  parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR,
  parameter logic [31:0] IM_LO      = CPU_IM_LO,
  parameter logic [31:0] IM_HI      = CPU_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic [15:0] d_imm16,
  output logic        d_valid,
  output logic        d_adel
);

  logic [31:0] pc_q, pc_d;
  pc_sel_e     pc_sel;
  logic        fault;

  if_stage_if ifid_bus ();

  // exc_req beats stall, and stall beats jump_en so a held slot never redirects.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (exc_req)      pc_sel = PC_SEL_EXC;
    else if (stall)   pc_sel = PC_SEL_HOLD;
    else if (jump_en) pc_sel = PC_SEL_JUMP;
  end

  always_comb begin
    pc_d = pc_q + PC_STEP;
    unique case (pc_sel)
      PC_SEL_EXC:  pc_d = EXC_VECTOR;
      PC_SEL_HOLD: pc_d = pc_q;
      PC_SEL_JUMP: pc_d = jump_target;
      PC_SEL_SEQ:  pc_d = pc_q + PC_STEP;
      default:     pc_d = pc_q + PC_STEP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign fault = fetch_fault(pc_q, IM_LO, IM_HI);

  assign ifid_bus.flush   = exc_req;
  assign ifid_bus.cap_en  = ~stall;
  assign ifid_bus.f_pc    = pc_q;
  assign ifid_bus.f_instr = fault ? CPU_NOP : imem_rdata;
  assign ifid_bus.f_adel  = fault;

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .ifid  (ifid_bus.slave)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign d_instr   = ifid_bus.d_instr;
  assign d_pc      = ifid_bus.d_pc;
  assign d_valid   = ifid_bus.d_valid;
  assign d_adel    = ifid_bus.d_adel;
  assign d_pc8     = ifid_bus.d_pc + LINK_OFFSET;
  assign d_imm16   = ifid_bus.d_instr[15:0];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset sequences, then random
// stimulus checked against a behavioural model of the fetch rules.
module tb_if_stage;

  localparam logic [31:0] T_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] T_EXC      = 32'h0000_4180;
  localparam logic [31:0] T_LO       = 32'h0000_3000;
  localparam logic [31:0] T_HI       = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic [15:0] d_imm16;
  logic        d_valid;
  logic        d_adel;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_dpc;
  logic        m_valid, m_adel;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_pc8       (d_pc8),
    .d_imm16     (d_imm16),
    .d_valid     (d_valid),
    .d_adel      (d_adel)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] + 16'h1234};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        stall;
    logic        jump_en;
    logic        exc_req;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_dpc;
    logic        exp_valid;
    logic        exp_adel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic j, input logic e, input logic [31:0] t,
                              input logic [31:0] p, input logic [31:0] dp,
                              input logic v, input logic ad);
    vec_t r;
    r.stall = s; r.jump_en = j; r.exc_req = e; r.tgt = t;
    r.exp_pc = p; r.exp_dpc = dp; r.exp_valid = v; r.exp_adel = ad;
    return r;
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [31:0] e_pc, input logic [31:0] e_dpc,
                           input logic [31:0] e_instr, input logic e_valid, input logic e_adel);
    chk("pc",        pc,                e_pc);
    chk("imem_addr", imem_addr,         e_pc);
    chk("d_pc",      d_pc,              e_dpc);
    chk("d_pc8",     d_pc8,             e_dpc + 32'd8);
    chk("d_instr",   d_instr,           e_instr);
    chk("d_imm16",   {16'h0, d_imm16},  {16'h0, e_instr[15:0]});
    chk("d_valid",   {31'h0, d_valid},  {31'h0, e_valid});
    chk("d_adel",    {31'h0, d_adel},   {31'h0, e_adel});
  endtask

  // Driver: present inputs, cross one rising edge, settle past it.
  task automatic drive(input logic s, input logic j, input logic [31:0] t, input logic e);
    stall = s; jump_en = j; jump_target = t; exc_req = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < T_LO) || (a > T_HI);
  endfunction

  // Reference model step from the architectural rules (uses pre-edge state).
  task automatic model_step(input logic s, input logic j, input logic [31:0] t, input logic e);
    if (e) begin
      m_pc = T_EXC; m_instr = 32'h0; m_dpc = 32'h0; m_valid = 1'b0; m_adel = 1'b0;
    end else if (!s) begin
      m_dpc   = m_pc;
      m_valid = 1'b1;
      m_adel  = is_fault(m_pc);
      m_instr = m_adel ? 32'h0 : mem_word(m_pc);
      m_pc    = j ? t : m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return T_LO + 32'($urandom_range(0, (T_HI - T_LO) / 4)) * 4;
    else if (r == 6) return T_LO + 32'($urandom_range(0, 100)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 7) return T_LO - 32'($urandom_range(1, 64)) * 4;
    else if (r == 8) return T_HI + 32'($urandom_range(1, 64)) * 4;
    else             return T_HI;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] ei;
    logic s, j, e;
    logic [31:0] t;

    reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_target = 32'h0; exc_req = 1'b0;

    tbl.push_back(mk(0,0,0,32'h0,       32'h3004, 32'h3000, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3008, 32'h3004, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h300C, 32'h3008, 1,0));
    tbl.push_back(mk(0,1,0,32'h3008,    32'h3008, 32'h300C, 1,0));
    tbl.push_back(mk(0,1,0,32'h3100,    32'h3100, 32'h3008, 1,0));
    tbl.push_back(mk(0,1,0,32'h3010,    32'h3010, 32'h3100, 1,0));
    tbl.push_back(mk(1,1,0,32'h5000,    32'h3010, 32'h3100, 1,0));
    tbl.push_back(mk(1,1,0,32'h5000,    32'h3010, 32'h3100, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3014, 32'h3010, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3018, 32'h3014, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h301C, 32'h3018, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3020, 32'h301C, 1,0));
    tbl.push_back(mk(1,1,1,32'h5000,    32'h4180, 32'h0,    0,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h4184, 32'h4180, 1,0));
    tbl.push_back(mk(0,1,0,32'h3002,    32'h3002, 32'h4184, 1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3006, 32'h3002, 1,1));
    tbl.push_back(mk(0,1,0,32'h7000,    32'h7000, 32'h3006, 1,1));
    tbl.push_back(mk(0,0,0,32'h0,       32'h7004, 32'h7000, 1,1));
    tbl.push_back(mk(0,1,0,32'h6FFC,    32'h6FFC, 32'h7004, 1,1));
    tbl.push_back(mk(0,0,0,32'h0,       32'h7000, 32'h6FFC, 1,0));
    tbl.push_back(mk(0,1,0,32'h2FFC,    32'h2FFC, 32'h7000, 1,1));
    tbl.push_back(mk(0,0,0,32'h0,       32'h3000, 32'h2FFC, 1,1));
    tbl.push_back(mk(0,1,0,32'hFFFFFFFC,32'hFFFFFFFC,32'h3000,1,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h0,    32'hFFFFFFFC,1,1));
    tbl.push_back(mk(0,0,0,32'h0,       32'h4,    32'h0,    1,1));
    tbl.push_back(mk(0,0,1,32'h0,       32'h4180, 32'h0,    0,0));
    tbl.push_back(mk(1,0,0,32'h0,       32'h4180, 32'h0,    0,0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h4184, 32'h4180, 1,0));

    // Reset state, including the derived link/immediate outputs
    repeat (2) @(posedge clk);
    #1;
    check_all(T_PC_RESET, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      v  = tbl[i];
      drive(v.stall, v.jump_en, v.tgt, v.exc_req);
      ei = (v.exp_valid && !v.exp_adel) ? mem_word(v.exp_dpc) : 32'h0;
      check_all(v.exp_pc, v.exp_dpc, ei, v.exp_valid, v.exp_adel);
    end

    // Asynchronous reset between edges takes effect without a clock
    drive(0, 0, 32'h0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all(T_PC_RESET, 32'h0, 32'h0, 1'b0, 1'b0);

    // Pending stall/redirect while in reset is discarded
    drive(1, 1, 32'h5000, 0);
    check_all(T_PC_RESET, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; jump_en = 1'b0;
    drive(0, 0, 32'h0, 0);
    check_all(32'h3004, 32'h3000, mem_word(32'h3000), 1'b1, 1'b0);

    // Randomized phase against the model
    m_pc = 32'h3004; m_dpc = 32'h3000; m_instr = mem_word(32'h3000);
    m_valid = 1'b1; m_adel = 1'b0;
    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 4) == 0);
      e = ($urandom_range(0, 24) == 0);
      t = rand_target();
      model_step(s, j, t, e);
      drive(s, j, t, e);
      check_all(m_pc, m_dpc, m_instr, m_valid, m_adel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
